alu_seq: RTL and testbench
==========================

# alu_seq

Registered, parametrised ALU for the DE0 MCU datapath. It is the successor of the combinational W/literal ALU: same operand roles (literal/IR operand and W operand), generalised to WIDTH bits. It adds a status register (Z, C, N), carry-using operations, and an iterative multi-cycle multiplier behind a start/busy/done handshake. It sits between the W register / instruction register and the W write-back path, and its flags feed the branch logic.

## Interface
- WIDTH, 8, operand/result width (≥4)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  issue operation; sampled only when busy=0
- op  in  4  operation select (latched at accept)
- w_q  in  WIDTH  W operand (latched at accept)
- ir_q  in  WIDTH  literal/IR operand (latched at accept)
- alu_q  out  WIDTH  registered result (multiply: low half)
- mul_hi_q  out  WIDTH  registered high half of last multiply
- z_flag, c_flag, n_flag  out  1 each  status register
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse, result/flags valid

## Operation
- Accept: rising edge with start=1, busy=0. op, w_q and ir_q are captured; later input changes have no effect.
- Ops (b = ir_q, a = w_q):
  - 0 ADD: b+a
  - 1 SUB: b−a
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 PASS: b
  - 6 ADC: b+a+C
  - 7 SBC: b−a−!C
  - 8 RLC: {b[W-2:0],C}, new C=b[W-1]
  - 9 RRC: {C,b[W-1:1]}, new C=b[0]
  - 10 MUL: unsigned b×a
  - 11–15: behave as ADD
- All arithmetic is modulo 2^WIDTH.
- Carry:
  - ADD/ADC: C = carry-out.
  - SUB/SBC: C = no-borrow, i.e. 1 when b ≥ a (+ borrow-in).
  - AND/OR/XOR/PASS: C unchanged.
  - MUL: C = (high half ≠ 0).
- Z = result==0. For MUL, Z is taken over the full 2·WIDTH-bit product.
- N = result MSB. For MUL, N is the MSB of the high half.
- Flags, alu_q and mul_hi_q update only at completion; otherwise they hold. mul_hi_q changes only on MUL.
- FSM states: IDLE, MUL.
  - IDLE: non-MUL accept completes in the same edge. MUL accept → MUL, busy=1, iteration counter=0, accumulator cleared.
  - MUL: shift-add, one multiplier bit per cycle. On the WIDTH-th iteration edge: write product, set flags, go to IDLE, busy=0.
- start while busy: ignored, not queued.

## Timing
- Reset (asynchronous, immediate): alu_q=0, mul_hi_q=0, Z=0, C=0, N=0, busy=0, done=0, state=IDLE, counter=0.
- Single-cycle ops: accept at edge E0. Result/flags visible after E0; done=1 for the cycle E0..E1.
- MUL:
  - Accept at E0; busy=1 from E0 until edge E0+WIDTH.
  - Result/flags are written at E0+WIDTH; done=1 for the cycle after it.
  - Latency: WIDTH cycles.
- Back-to-back: start may be high in the same cycle done is high. It is accepted at that edge because busy=0, giving one op/cycle for single-cycle ops.
- Carry-using ops use the C value present at accept, including C just written by the previous op.
- Reset mid-MUL: abort; no done pulse; all outputs go to reset values.

## Test plan
- ADD, WIDTH=8: ir_q=0xFF, w_q=0x01 → next cycle alu_q=0x00, Z=1, C=1, N=0, done pulse of one cycle.
- SUB then SBC: ir_q=0x03, w_q=0x05 → alu_q=0xFE, C=0, N=1. Follow immediately with SBC ir_q=0x10, w_q=0x01 → alu_q=0x0E, C=1 (back-to-back accept).
- ADC/RLC chain with C=1:
  - ADC ir_q=0x10, w_q=0x20 → 0x31, C=0.
  - Then set C via ADD 0x80+0x80 (→ 0x00, C=1, Z=1).
  - Then RLC ir_q=0x80 → 0x01, C=1, Z=0.
- MUL: ir_q=0x0F, w_q=0x11, start 1 cycle → busy high exactly 8 cycles. Then alu_q=0xFF, mul_hi_q=0x00, C=0, Z=0, single done. A start pulse at cycle 3 of busy is ignored. MUL 0xFF×0xFF → hi 0xFE, lo 0x01, C=1, N=1.
- Logic ops hold C: with C=1, AND ir_q=0xF0, w_q=0x0F → alu_q=0x00, Z=1, C stays 1.
- Reset mid-MUL: assert rst_n=0 at busy cycle 4, asynchronously → all outputs 0 immediately, no done. After release, a new ADD completes normally.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with Z/C/N status and an iterative
// shift-add multiplier behind a start/busy/done handshake.
// Single-cycle ops complete on the accepting edge. MUL takes WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] w_q,
  input  logic [WIDTH-1:0] ir_q,
  output logic [WIDTH-1:0] alu_q,
  output logic [WIDTH-1:0] mul_hi_q,
  output logic             z_flag,
  output logic             c_flag,
  output logic             n_flag,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {IDLE, MUL} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_PASS = 4'd5,
    OP_ADC  = 4'd6,
    OP_SBC  = 4'd7,
    OP_RLC  = 4'd8,
    OP_RRC  = 4'd9,
    OP_MUL  = 4'd10
  } op_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;

  op_t                op_sel;
  logic               accept;
  logic               is_mul;
  logic               last_iter;

  // Single-cycle ALU outputs
  logic [WIDTH-1:0]   res;
  logic               c_new;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH:0]     add_sum;

  // Multiplier step outputs
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_next;

  assign op_sel    = op_t'(op);
  assign busy      = (state_q == MUL);
  assign accept    = start && (state_q == IDLE);
  assign is_mul    = (op_sel == OP_MUL);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Combinational result and carry of the single-cycle operations.
  // Subtraction is done as b + ~a + cin so that carry-out means no-borrow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    res     = '0;
    c_new   = c_flag;
    add_b   = w_q;
    add_cin = 1'b0;
    case (op_sel)
      OP_SUB: begin add_b = ~w_q; add_cin = 1'b1;   end
      OP_ADC: begin add_b = w_q;  add_cin = c_flag; end
      OP_SBC: begin add_b = ~w_q; add_cin = c_flag; end
      default: ;
    endcase
    add_sum = {1'b0, ir_q} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    case (op_sel)
      OP_AND:  res = ir_q & w_q;
      OP_OR:   res = ir_q | w_q;
      OP_XOR:  res = ir_q ^ w_q;
      OP_PASS: res = ir_q;
      OP_RLC: begin
        res   = {ir_q[WIDTH-2:0], c_flag};
        c_new = ir_q[WIDTH-1];
      end
      OP_RRC: begin
        res   = {c_flag, ir_q[WIDTH-1:1]};
        c_new = ir_q[0];
      end
      default: begin
        res   = add_sum[WIDTH-1:0];
        c_new = add_sum[WIDTH];
      end
    endcase
  end

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole product right.
  always_comb begin
    step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_next = {step_sum, prod_q[WIDTH-1:1]};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    else        state_q <= state_d;
  end

  // FSM next-state: IDLE -> MUL on a MUL accept, back after WIDTH steps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL:  if (last_iter)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: result/flag write-back, multiplier registers, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the multiplier working registers are reset too, so an aborted
      // multiply leaves no stale partial product behind.
      alu_q    <= '0;
      mul_hi_q <= '0;
      z_flag   <= 1'b0;
      c_flag   <= 1'b0;
      n_flag   <= 1'b0;
      done     <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand_q <= ir_q;
              prod_q  <= {{WIDTH{1'b0}}, w_q};
              cnt_q   <= '0;
            end else begin
              alu_q  <= res;
              c_flag <= c_new;
              z_flag <= ~|res;
              n_flag <= res[WIDTH-1];
              done   <= 1'b1;
            end
          end
        end
        MUL: begin
          prod_q <= prod_next;
          cnt_q  <= cnt_q + 1'b1;
          if (last_iter) begin
            cnt_q    <= '0;
            alu_q    <= prod_next[WIDTH-1:0];
            mul_hi_q <= prod_next[2*WIDTH-1:WIDTH];
            c_flag   <= |prod_next[2*WIDTH-1:WIDTH];
            z_flag   <= ~|prod_next;
            n_flag   <= prod_next[2*WIDTH-1];
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed test-plan steps plus random ops, all checked against
// an arithmetic reference model of the ALU kept in the bench.
module tb_alu_seq;

  localparam int W = 8;
  localparam longint MASK = (64'sd1 <<< W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] w_q = '0;
  logic [W-1:0] ir_q = '0;
  logic [W-1:0] alu_q;
  logic [W-1:0] mul_hi_q;
  logic         z_flag, c_flag, n_flag, busy, done;

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint m_alu, m_hi;
  int     m_z, m_c, m_n, m_busy;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .w_q      (w_q),
    .ir_q     (ir_q),
    .alu_q    (alu_q),
    .mul_hi_q (mul_hi_q),
    .z_flag   (z_flag),
    .c_flag   (c_flag),
    .n_flag   (n_flag),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_alu = 0; m_hi = 0; m_z = 0; m_c = 0; m_n = 0; m_busy = 0;
  endtask

  // Completion of operation o with a = w_q, b = ir_q.
  function automatic void model_op(input int o, input longint a, input longint b);
    longint s, p;
    case (o)
      1: begin s = b - a;          m_c = (s >= 0);  m_alu = s & MASK; end
      2: m_alu = b & a;
      3: m_alu = b | a;
      4: m_alu = b ^ a;
      5: m_alu = b;
      6: begin s = b + a + m_c;    m_c = (s > MASK); m_alu = s & MASK; end
      7: begin s = b - a - (1 - m_c); m_c = (s >= 0); m_alu = s & MASK; end
      8: begin s = ((b << 1) | m_c) & MASK; m_c = int'((b >> (W-1)) & 1); m_alu = s; end
      9: begin s = (longint'(m_c) << (W-1)) | (b >> 1); m_c = int'(b & 1); m_alu = s; end
      10: begin
        p = b * a;
        m_hi  = p >> W;
        m_alu = p & MASK;
        m_c   = (m_hi != 0);
        m_z   = (p == 0);
        m_n   = int'((m_hi >> (W-1)) & 1);
        return;
      end
      default: begin s = b + a; m_c = (s > MASK); m_alu = s & MASK; end
    endcase
    m_z = (m_alu == 0);
    m_n = int'((m_alu >> (W-1)) & 1);
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_alu"},  64'(alu_q),    64'(m_alu));
    check({tag, "_hi"},   64'(mul_hi_q), 64'(m_hi));
    check({tag, "_z"},    64'(z_flag),   64'(m_z));
    check({tag, "_c"},    64'(c_flag),   64'(m_c));
    check({tag, "_n"},    64'(n_flag),   64'(m_n));
    check({tag, "_busy"}, 64'(busy),     64'(m_busy));
  endtask

  // Single-cycle op; leaves start high so consecutive calls are back-to-back.
  task automatic do_op(input int o, input int a, input int b);
    start = 1'b1; op = 4'(o); w_q = W'(a); ir_q = W'(b);
    @(posedge clk); #1;
    model_op(o, a, b);
    check($sformatf("op%0d_done", o), 64'(done), 64'd1);
    compare_all($sformatf("op%0d", o));
  endtask

  task automatic idle();
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_done", 64'(done), 64'd0);
    compare_all("idle");
  endtask

  // Multiply with busy-length measurement; optionally pulses start mid-run.
  task automatic do_mul(input int a, input int b, input bit inject);
    int cyc;
    start = 1'b1; op = 4'd10; w_q = W'(a); ir_q = W'(b);
    @(posedge clk); #1;
    start = 1'b0;
    w_q = W'($urandom); ir_q = W'($urandom);
    m_busy = 1;
    check("mul_acc_done", 64'(done), 64'd0);
    compare_all("mul_acc");
    cyc = 0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (busy !== 1'b1 || cyc >= 3*W) break;
      check("mul_busy_done", 64'(done), 64'd0);
      compare_all("mul_hold");
      if (inject && cyc == 2) begin start = 1'b1; op = 4'd0; end
      if (inject && cyc == 3) start = 1'b0;
    end
    start = 1'b0;
    m_busy = 0;
    check("mul_cycles", 64'(cyc), 64'(W));
    model_op(10, a, b);
    check("mul_done", 64'(done), 64'd1);
    compare_all("mul");
    @(posedge clk); #1;
    check("mul_done_once", 64'(done), 64'd0);
    compare_all("mul_after");
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_done", 64'(done), 64'd0);
    compare_all("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD wrap to zero with carry
    do_op(0, 8'h01, 8'hFF);
    check("add_lit_alu", 64'(alu_q), 64'h00);
    check("add_lit_zc", 64'({z_flag, c_flag, n_flag}), 64'b110);
    idle();

    // SUB then back-to-back SBC
    do_op(1, 8'h05, 8'h03);
    check("sub_lit", 64'({alu_q, c_flag, n_flag}), 64'({8'hFE, 2'b01}));
    do_op(7, 8'h01, 8'h10);
    check("sbc_lit", 64'({alu_q, c_flag}), 64'({8'h0E, 1'b1}));

    // ADC/ADD/RLC carry chain
    do_op(6, 8'h20, 8'h10);
    check("adc_lit", 64'({alu_q, c_flag}), 64'({8'h31, 1'b0}));
    do_op(0, 8'h80, 8'h80);
    check("add80_lit", 64'({alu_q, z_flag, c_flag}), 64'({8'h00, 2'b11}));
    do_op(8, 8'h00, 8'h80);
    check("rlc_lit", 64'({alu_q, z_flag, c_flag}), 64'({8'h01, 2'b01}));
    do_op(9, 8'h00, 8'h02);
    idle();

    // Multiplies, first with an ignored start during busy
    do_mul(8'h11, 8'h0F, 1'b1);
    check("mul1_lit", 64'({mul_hi_q, alu_q}), 64'h00FF);
    do_mul(8'hFF, 8'hFF, 1'b0);
    check("mul2_lit", 64'({mul_hi_q, alu_q, c_flag, n_flag}), 64'({16'hFE01, 2'b11}));

    // Logic op holds C
    do_op(2, 8'h0F, 8'hF0);
    check("and_lit", 64'({alu_q, z_flag, c_flag}), 64'({8'h00, 2'b11}));
    idle();

    // Random ops, mixing back-to-back, idle gaps and multiplies
    for (int i = 0; i < 60; i++) begin
      int o;
      o = (i % 10 == 0) ? 10 : int'($urandom_range(0, 15));
      if (o == 10) do_mul(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
      else         do_op(o, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    // Reset during a multiply
    start = 1'b1; op = 4'd10; w_q = 8'hAB; ir_q = 8'hCD;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("rstmid_done", 64'(done), 64'd0);
    compare_all("rstmid");
    @(posedge clk); #1;
    check("rstmid_done2", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstmid_done3", 64'(done), 64'd0);
    compare_all("rstrel");
    do_op(0, 8'h22, 8'h11);
    check("post_rst_add", 64'(alu_q), 64'h33);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
